// File: rtl/instr_sequencer_if.sv
// Sequencer bus: run/instruction/opcode-FSM feedback in, fetch and grant controls out.
// The instr_count member exists only when SEQ_INSTR_COUNT_EN is defined.
interface instr_sequencer_if;
    logic        run;
    logic [15:0] instruction;
    logic [15:0] ex_done;
    logic [15:0] ex_triEN;
    logic        IF_active;
    logic        memRd;
    logic        irIn;
    logic [15:0] grant;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
`ifdef SEQ_INSTR_COUNT_EN
    logic [15:0] instr_count;

    modport master (
        output run, instruction, ex_done, ex_triEN,
        input  IF_active, memRd, irIn, grant,
        input  halted, fault, fault_code, instr_count
    );

    modport slave (
        input  run, instruction, ex_done, ex_triEN,
        output IF_active, memRd, irIn, grant,
        output halted, fault, fault_code, instr_count
    );
`else
    modport master (
        output run, instruction, ex_done, ex_triEN,
        input  IF_active, memRd, irIn, grant,
        input  halted, fault, fault_code
    );

    modport slave (
        input  run, instruction, ex_done, ex_triEN,
        output IF_active, memRd, irIn, grant,
        output halted, fault, fault_code
    );
`endif
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer with exec watchdog and bus-contention trap.
// Optional retired-instruction counter enabled by SEQ_INSTR_COUNT_EN.
module instr_sequencer #(
    parameter int unsigned EXEC_TIMEOUT = 15,
    parameter logic [3:0]  HALT_OP      = 4'b1111
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC, S_HALT, S_FAULT
    } state_e;

    localparam logic [7:0] WD_LAST = 8'(EXEC_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [7:0]  wd_q, wd_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        if_active_q, if_active_d;
    logic        mem_rd_q, mem_rd_d;
    logic        ir_in_q, ir_in_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [15:0] grant_q, grant_d;

    logic [15:0] op_hot;
    logic        done_hit;
    logic        contention;
    logic        timeout;
    logic        unused_ok;

    assign op_hot     = 16'd1 << opcode_q;
    assign done_hit   = bus.ex_done[opcode_q];
    assign contention = |(bus.ex_triEN & ~op_hot);
    assign timeout    = (wd_q == WD_LAST);
    assign unused_ok  = ^bus.instruction[11:0];

    // Next-state logic; outputs are decoded from the next state so they register with it
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        wd_d         = wd_q;
        fault_code_d = fault_code_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH1;
            end
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = bus.instruction[15:12];
                wd_d     = 8'd0;
                state_d  = (opcode_d == HALT_OP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                wd_d = wd_q + 8'd1;
                if (contention) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'b10;
                end else if (done_hit) begin
                    state_d = bus.run ? S_FETCH1 : S_IDLE;
                end else if (timeout) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'b01;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        if_active_d = (state_d != S_EXEC);
        mem_rd_d    = (state_d == S_FETCH1);
        ir_in_d     = (state_d == S_FETCH2);
        halted_d    = (state_d == S_HALT);
        fault_d     = (state_d == S_FAULT);
        grant_d     = (state_d == S_EXEC) ? (16'd1 << opcode_d) : 16'd0;
    end

    // State, watchdog, latched opcode and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            opcode_q     <= 4'd0;
            wd_q         <= 8'd0;
            fault_code_q <= 2'b00;
            if_active_q  <= 1'b1;
            mem_rd_q     <= 1'b0;
            ir_in_q      <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            grant_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            wd_q         <= wd_d;
            fault_code_q <= fault_code_d;
            if_active_q  <= if_active_d;
            mem_rd_q     <= mem_rd_d;
            ir_in_q      <= ir_in_d;
            halted_q     <= halted_d;
            fault_q      <= fault_d;
            grant_q      <= grant_d;
        end
    end

    assign bus.IF_active  = if_active_q;
    assign bus.memRd      = mem_rd_q;
    assign bus.irIn       = ir_in_q;
    assign bus.grant      = grant_q;
    assign bus.halted     = halted_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;

`ifdef SEQ_INSTR_COUNT_EN
    logic [15:0] count_q, count_d;
    logic        count_inc;

    assign count_inc = ((state_q == S_DECODE) && (bus.instruction[15:12] == HALT_OP))
                     || ((state_q == S_EXEC) && !contention && done_hit);
    assign count_d   = count_q + {15'd0, count_inc};

    // Retired-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= 16'd0;
        else      count_q <= count_d;
    end

    assign bus.instr_count = count_q;
`endif

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter EXEC_TIMEOUT, default 15, giving the maximum number of EXEC cycles allowed without a done (range 1..255).
REQ-002 The block SHALL have parameter HALT_OP, default 4'b1111, giving the opcode that halts the sequencer.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port run, input, 1 bit: high level permits fetching.
REQ-006 The block SHALL have port instruction, input, 16 bits: instruction register contents; the opcode is bits [15:12].
REQ-007 The block SHALL have port ex_done, input, 16 bits: done pulse from each opcode FSM, indexed by opcode.
REQ-008 The block SHALL have port ex_triEN, input, 16 bits: bus-drive enable from each opcode FSM, indexed by opcode.
REQ-009 The block SHALL have port IF_active, output, 1 bit: fetch in progress; holds all opcode FSMs in their idle state.
REQ-010 The block SHALL have port memRd, output, 1 bit: program memory read strobe.
REQ-011 The block SHALL have port irIn, output, 1 bit: instruction register load enable.
REQ-012 The block SHALL have port grant, output, 16 bits: one-hot execute grant for the decoded opcode.
REQ-013 The block SHALL have port halted, output, 1 bit: halt opcode has been executed.
REQ-014 The block SHALL have port fault, output, 1 bit: sticky error flag.
REQ-015 The block SHALL have port fault_code, output, 2 bits: 01 = timeout, 10 = bus contention.

Function
REQ-016 States SHALL be IDLE, FETCH1, FETCH2, DECODE, EXEC, HALT and FAULT; all outputs SHALL be registered and decoded from the state register only.
REQ-017 IDLE SHALL go to FETCH1 on the first clock edge where run=1, and SHALL otherwise hold.
REQ-018 In FETCH1, IF_active and memRd SHALL be 1, and the next state SHALL be FETCH2.
REQ-019 In FETCH2, IF_active and irIn SHALL be 1, and the next state SHALL be DECODE.
REQ-020 In DECODE, IF_active SHALL be 1 and opcode SHALL be latched from instruction[15:12]; the next state SHALL be HALT if opcode==HALT_OP, otherwise EXEC.
REQ-021 In EXEC, IF_active SHALL be 0, grant SHALL equal one-hot(opcode), and the 8-bit watchdog counter SHALL increment each cycle from 0 at EXEC entry.
REQ-022 When ex_done[opcode]=1 in EXEC, the next state SHALL be FETCH1 if run=1, otherwise IDLE.
REQ-023 Bits of ex_done other than ex_done[opcode] SHALL be ignored.
REQ-024 When the watchdog reaches EXEC_TIMEOUT without done, the next state SHALL be FAULT with fault_code=01.
REQ-025 When ex_done[opcode] and timeout occur in the same cycle, done SHALL win.
REQ-026 When ex_triEN[i]=1 for any i≠opcode during EXEC, the next state SHALL be FAULT with fault_code=10.
REQ-027 When contention and done occur in the same cycle, contention SHALL win.
REQ-028 When contention and timeout occur in the same cycle, the contention code SHALL be used.
REQ-029 The fetch-to-EXEC latency SHALL be 3 cycles (FETCH1, FETCH2, DECODE), and the done-to-next-FETCH1 latency SHALL be 1 cycle.
REQ-030 HALT SHALL be terminal: halted=1, grant=0, IF_active=1; only reset exits it.
REQ-031 FAULT SHALL be terminal: fault=1, fault_code held, grant=0, IF_active=1; only reset exits it.
REQ-032 Deasserting run SHALL be honoured only in IDLE and at instruction completion, and SHALL never abort EXEC.
REQ-033 grant SHALL be all-zero in every state other than EXEC.

Reset
REQ-034 When rst=0, the block SHALL immediately, without a clock, enter IDLE and set IF_active=1, memRd=0, irIn=0, grant=0, halted=0, fault=0, fault_code=00, watchdog=0 and the latched opcode=0.
REQ-035 Reset asserted mid-EXEC SHALL drop grant asynchronously.
REQ-036 After reset release, the first state change SHALL occur on the first clock edge with run=1.

Configuration
REQ-037 With SEQ_INSTR_COUNT_EN defined, the block SHALL add output instr_count[15:0], reset to 0.
REQ-038 instr_count SHALL increment by 1 on each accepted ex_done in EXEC, SHALL count HALT entry as one instruction, and SHALL wrap from 0xFFFF to 0x0000.
REQ-039 Without SEQ_INSTR_COUNT_EN, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-040 Reset, run=1, instruction=0x6285, with ex_done[6] pulsed on the 4th EXEC cycle -> IF_active 1,1,1 then 0; grant=0x0040 for 4 cycles; FETCH1 is re-entered 1 cycle after done.
REQ-041 Opcode 0x3 with ex_done never asserted -> after 15 EXEC cycles, fault=1, fault_code=01, grant=0; the state persists until rst=0.
REQ-042 Opcode 0x6 granted and ex_triEN=0x0041 in EXEC cycle 2 -> FAULT with fault_code=10 on the next edge, even when ex_done[6]=1 in the same cycle.
REQ-043 instruction=0xF000 -> after DECODE, halted=1 and grant stays 0; a 10-cycle run toggle causes no state change.
REQ-044 run dropped during EXEC with done arriving later -> the instruction completes, the block enters IDLE, and no FETCH1 occurs until run=1.
REQ-045 With SEQ_INSTR_COUNT_EN, preload by executing 65535 instructions and then one more -> instr_count=0x0000; rst=0 asserted mid-EXEC -> all outputs reach reset values without a clock edge.
